// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell walks the captured operands while a borrow
// flop carries the chain between bits. Results appear only at completion.
module serial_full_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] sa, sb, acc, acc_next;
  logic [CW-1:0]    cnt;
  logic             br, d, br_next;
  logic             load, last;

  // Full-subtractor cell on the current LSBs of the working operands.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Result bits enter from the MSB side so bit i settles at position i.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_next = d;
    end else begin : g_accn
      assign acc_next = {d, acc[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: accept start only when idle, finish on the last bit.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working operands, borrow chain, partial result and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      acc <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      acc <= '0;
      br  <= bin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= acc_next;
      br  <= br_next;
      cnt <= cnt + 1'b1;
    end
  end

  // Visible outputs: updated only on completion, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        diff <= acc_next;
        bout <= br_next;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Scoreboard bench for serial_full_subtractor (WIDTH=4): stimulus pushes the
// expected result and completion cycle; a monitor pops on each done pulse.
module tb_serial_full_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
  logic         busy;

  serial_full_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int unsigned  cyc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called just after a rising edge with the DUT idle; start is sampled on the next edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                       input logic [W-1:0] ed, input logic eb);
    exp_t e;
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    e.diff = ed;
    e.bout = eb;
    e.cyc  = cyc + 1 + W;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    q.delete();
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 diff=%0h bout=%0b, expected no pulse", diff, bout);
      end else begin
        e = q.pop_front();
        check("diff", diff, e.diff);
        check("bout", bout, e.bout);
        check("latency_cycle", cyc, e.cyc);
        check("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] r;
    logic [W-1:0] va, vb;
    logic vbin;

    #1 rst_n = 1'b0;
    #1;
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    #1 check("busy_after_accept", busy, 1);
    wait_idle();
    issue(4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    wait_idle();
    issue(4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    wait_idle();
    issue(4'h8, 4'h1, 1'b1, 4'd6, 1'b0);
    wait_idle();

    // start while busy must be ignored
    issue(4'd5, 4'd2, 1'b0, 4'd3, 1'b0);
    @(posedge clk);
    #1;
    a = 4'd0;
    b = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // start during the done cycle is accepted
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    repeat (W) @(posedge clk);
    #1;
    check("done_at_restart", done, 1);
    issue(4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of an operation
    issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_diff", diff, 0);
    check("midreset_bout", bout, 0);
    check("midreset_done", done, 0);
    check("midreset_busy", busy, 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;
    issue(4'd7, 4'd7, 1'b0, 4'd0, 1'b0);
    wait_idle();

    // Exhaustive sweep, back-to-back
    for (int i = 0; i < 512; i++) begin
      va   = 4'(i >> 5);
      vb   = 4'(i >> 1);
      vbin = i[0];
      r = {1'b0, va} - {1'b0, vb} - {4'b0, vbin};
      issue(va, vb, vbin, r[W-1:0], r[W]);
      repeat (W) @(posedge clk);
      #1;
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
